// File: rtl/mem_cmd_arbiter_pkg.sv
// rtl/mem_cmd_arbiter_pkg.sv - shared constants and types for the MIG command arbiter
`timescale 1ns/1ps
package mem_cmd_arbiter_pkg;

   localparam int ADDR_W_DEF = 30;
   localparam int BL_W_DEF   = 6;

   // Upper byte-address bits of the graphics region; the low 16 bits come from the requester.
   localparam logic [13:0] GRAPHICS_MEM_PREFIX = 14'h0040;

   localparam logic [2:0] MEM_CMD_WRITE = 3'b000;
   localparam logic [2:0] MEM_CMD_READ  = 3'b001;

   localparam logic [1:0] ARB_IDLE  = 2'd0;
   localparam logic [1:0] ARB_ISSUE = 2'd1;
   localparam logic [1:0] ARB_GAP   = 2'd2;

   typedef enum logic {
      GRANT_WR = 1'b0,
      GRANT_RD = 1'b1
   } grant_e;

   function automatic logic [2:0] instr_for(input grant_e g);
      return (g == GRANT_RD) ? MEM_CMD_READ : MEM_CMD_WRITE;
   endfunction

endpackage

// File: rtl/mem_cmd_arbiter_if.sv
// rtl/mem_cmd_arbiter_if.sv - requester and MIG command-port signals of the arbiter
`timescale 1ns/1ps
interface mem_cmd_arbiter_if #(
   parameter int ADDR_W = 30,
   parameter int BL_W   = 6
);
   logic              calib_done;
   logic              rd_req;
   logic [BL_W-1:0]   rd_bl;
   logic [ADDR_W-1:0] rd_byte_addr;
   logic              rd_ack;
   logic              wr_req;
   logic [BL_W-1:0]   wr_bl;
   logic [ADDR_W-1:0] wr_byte_addr;
   logic              wr_ack;
   logic              mem_cmd_en;
   logic [2:0]        mem_cmd_instr;
   logic [BL_W-1:0]   mem_cmd_bl;
   logic [ADDR_W-1:0] mem_cmd_byte_addr;
   logic              mem_cmd_full;

   modport slave (
      input  calib_done, rd_req, rd_bl, rd_byte_addr, wr_req, wr_bl, wr_byte_addr, mem_cmd_full,
      output rd_ack, wr_ack, mem_cmd_en, mem_cmd_instr, mem_cmd_bl, mem_cmd_byte_addr
   );

   modport master (
      output calib_done, rd_req, rd_bl, rd_byte_addr, wr_req, wr_bl, wr_byte_addr, mem_cmd_full,
      input  rd_ack, wr_ack, mem_cmd_en, mem_cmd_instr, mem_cmd_bl, mem_cmd_byte_addr
   );

endinterface

// File: rtl/mem_cmd_arbiter.sv
// rtl/mem_cmd_arbiter.sv - read-priority arbiter sharing one MIG command port with a bounded writer wait
`timescale 1ns/1ps
module mem_cmd_arbiter
   import mem_cmd_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int BL_W         = BL_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   mem_cmd_arbiter_if.slave  bus
);

   localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam logic [CNT_W-1:0]  LIMIT_C    = CNT_W'(STARVE_LIMIT);
   localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'({GRAPHICS_MEM_PREFIX, 16'h0000});

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  starve_q, starve_d;
   grant_e            grant_q, grant_d;
   logic              en_q, en_d;
   logic              rd_ack_q, rd_ack_d;
   logic              wr_ack_q, wr_ack_d;
   logic [BL_W-1:0]   bl_q, bl_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              sample;
   logic              wr_wins;

   assign sample  = bus.calib_done && !bus.mem_cmd_full && (bus.rd_req || bus.wr_req);
   assign wr_wins = bus.wr_req && (!bus.rd_req || (starve_q == LIMIT_C));

   always_comb begin
      state_d  = state_q;
      starve_d = starve_q;
      grant_d  = grant_q;
      bl_d     = bl_q;
      addr_d   = addr_q;
      en_d     = 1'b0;
      rd_ack_d = 1'b0;
      wr_ack_d = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            if (!bus.wr_req) starve_d = '0;
            if (sample) begin
               // Strobe and ack are registered here so they land together in the ISSUE cycle.
               if (wr_wins) begin
                  grant_d  = GRANT_WR;
                  bl_d     = bus.wr_bl;
                  addr_d   = bus.wr_byte_addr;
                  wr_ack_d = 1'b1;
                  starve_d = '0;
               end else begin
                  grant_d  = GRANT_RD;
                  bl_d     = bus.rd_bl;
                  addr_d   = bus.rd_byte_addr;
                  rd_ack_d = 1'b1;
                  if (bus.wr_req && (starve_q != LIMIT_C)) starve_d = starve_q + CNT_W'(1);
               end
               en_d    = 1'b1;
               state_d = ARB_ISSUE;
            end
         end
         ARB_ISSUE: state_d = ARB_GAP;
         default:   state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ARB_IDLE;
         starve_q <= '0;
         grant_q  <= GRANT_WR;
         en_q     <= 1'b0;
         rd_ack_q <= 1'b0;
         wr_ack_q <= 1'b0;
         bl_q     <= '0;
         addr_q   <= RESET_ADDR;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
         grant_q  <= grant_d;
         en_q     <= en_d;
         rd_ack_q <= rd_ack_d;
         wr_ack_q <= wr_ack_d;
         bl_q     <= bl_d;
         addr_q   <= addr_d;
      end
   end

   assign bus.mem_cmd_en        = en_q;
   assign bus.rd_ack            = rd_ack_q;
   assign bus.wr_ack            = wr_ack_q;
   assign bus.mem_cmd_instr     = instr_for(grant_q);
   assign bus.mem_cmd_bl        = bl_q;
   assign bus.mem_cmd_byte_addr = addr_q;

endmodule
